// File: rtl/aes_inv_subbytes_seq.sv
// Iterative AES InvSubBytes engine: BYTES_PER_CYCLE bytes per clock through an
// arithmetic inverse S-box (inverse affine, then GF(2^8) inversion as t^254).
module aes_inv_subbytes_seq #(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NSLICE = 16 / BYTES_PER_CYCLE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("aes_inv_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    work;
  logic [127:0]    work_nxt;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    logic [7:0] c;
    c = 8'h05;
    t = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      t[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ c[i];
    end
    return gf_inv(t);
  endfunction

  always_comb begin
    work_nxt = work;
    for (int unsigned j = 0; j < BYTES_PER_CYCLE; j++) begin
      work_nxt[127 - 8 * (32'(cnt) * BYTES_PER_CYCLE + j) -: 8] =
        inv_sbox(work[127 - 8 * (32'(cnt) * BYTES_PER_CYCLE + j) -: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_state;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work <= work_nxt;
          if (cnt == CW'(NSLICE - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_state = work;

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Bench for aes_inv_subbytes_seq: five instances (1,2,4,8,16 bytes/cycle) against
// a table model built from the forward S-box, plus literal vectors.
module tb_aes_inv_subbytes_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic         iv[5];
  logic         ir[5];
  logic         ov[5];
  logic         ordy[5];
  logic         bz[5];
  logic [127:0] is[5];
  logic [127:0] os[5];

  generate
    for (genvar g = 0; g < 5; g++) begin : g_dut
      aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(1 << g)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(iv[g]), .in_ready(ir[g]), .in_state(is[g]),
        .out_valid(ov[g]), .out_ready(ordy[g]), .out_state(os[g]),
        .busy(bz[g])
      );
    end
  endgenerate

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] fwd[256];
  logic [7:0] invt[256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  // Carry-less product then polynomial reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] model_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = invt[s[127 - 8 * k -: 8]];
    return r;
  endfunction

  // Transaction-level model: 0 idle, 1 running, 2 result held.
  int           m_st[5];
  int           m_cnt[5];
  logic [127:0] m_exp[5];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 5; i++) begin
      if (!rst_n) begin
        m_st[i] <= 0;
        m_cnt[i] <= 0;
      end else if (flush) begin
        m_st[i] <= 0;
      end else if (m_st[i] == 0) begin
        if (iv[i]) begin
          m_st[i] <= 1;
          m_cnt[i] <= 1;
          m_exp[i] <= model_sub(is[i]);
        end
      end else if (m_st[i] == 1) begin
        if (m_cnt[i] >= (16 >> i)) m_st[i] <= 2;
        else m_cnt[i] <= m_cnt[i] + 1;
      end else if (ordy[i]) begin
        m_st[i] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("in_ready[%0d]", i), 128'(ir[i]), 128'(m_st[i] == 0));
        chk($sformatf("out_valid[%0d]", i), 128'(ov[i]), 128'(m_st[i] == 2));
        chk($sformatf("busy[%0d]", i), 128'(bz[i]), 128'(m_st[i] != 0));
        if (m_st[i] == 2) chk($sformatf("out_state[%0d]", i), os[i], m_exp[i]);
      end
    end
  end

  task automatic wait_valid(input int i, inout int lat);
    while (!ov[i] && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  task automatic txn(input int i, input logic [127:0] d, input logic [127:0] expd);
    int lat;
    @(negedge clk);
    is[i] = d; iv[i] = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); iv[i] = 1'b0;
    wait_valid(i, lat);
    chk($sformatf("latency[%0d]", i), 128'(lat), 128'((16 >> i) + 1));
    chk($sformatf("result[%0d]", i), os[i], expd);
    ordy[i] = 1'b1;
    @(posedge clk);
    @(negedge clk); ordy[i] = 1'b0;
    chk($sformatf("ready_after[%0d]", i), 128'(ir[i]), 128'(1));
  endtask

  initial begin
    logic [7:0] inv;
    logic [7:0] v8;
    logic [127:0] d1, d2, e1, e2;
    int lat;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) invt[fwd[x]] = 8'(x);
    for (int i = 0; i < 5; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; is[i] = '0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("rst_in_ready", 128'(ir[i]), 128'(1));
      chk("rst_out_valid", 128'(ov[i]), 128'(0));
      chk("rst_busy", 128'(bz[i]), 128'(0));
      chk("rst_out_state", os[i], '0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    txn(2, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
    txn(2, {16{8'h63}}, {16{8'h00}});
    txn(2, {16{8'h00}}, {16{8'h52}});
    txn(2, {16{8'h16}}, {16{8'hff}});
    txn(2, {16{8'h7c}}, {16{8'h01}});

    for (int i = 0; i < 5; i++) begin
      for (int v = 0; v < 256; v++) begin
        v8 = 8'(v);
        txn(i, {16{fwd[v]}}, {16{v8}});
      end
    end

    // Backpressure with a second request held during DONE.
    d1 = 128'h0123456789abcdeffedcba9876543210;
    d2 = 128'hdeadbeef00112233445566778899aabb;
    e1 = model_sub(d1);
    e2 = model_sub(d2);
    @(negedge clk); is[2] = d1; iv[2] = 1'b1;
    @(posedge clk); lat = 1;
    @(negedge clk); iv[2] = 1'b0;
    wait_valid(2, lat);
    chk("bp_latency", 128'(lat), 128'(5));
    is[2] = d2; iv[2] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_valid", 128'(ov[2]), 128'(1));
      chk("bp_hold", os[2], e1);
      chk("bp_in_ready", 128'(ir[2]), 128'(0));
    end
    ordy[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); ordy[2] = 1'b0;
    chk("bp_release_ready", 128'(ir[2]), 128'(1));
    @(posedge clk); lat = 1;
    @(negedge clk); iv[2] = 1'b0;
    chk("bp_second_busy", 128'(bz[2]), 128'(1));
    wait_valid(2, lat);
    chk("bp_second_latency", 128'(lat), 128'(5));
    chk("bp_second_data", os[2], e2);
    ordy[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); ordy[2] = 1'b0;

    // Flush on the second RUN cycle.
    is[2] = d1; iv[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); iv[2] = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk);
    @(negedge clk); flush = 1'b0;
    chk("flush_busy", 128'(bz[2]), 128'(0));
    chk("flush_in_ready", 128'(ir[2]), 128'(1));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("flush_no_valid", 128'(ov[2]), 128'(0));
    end
    txn(2, d2, e2);

    // Flush while idle with a pending request: not accepted.
    @(negedge clk); flush = 1'b1; is[2] = d1; iv[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); flush = 1'b0; iv[2] = 1'b0;
    chk("flush_idle_busy", 128'(bz[2]), 128'(0));

    // Asynchronous reset between edges in the middle of RUN.
    @(negedge clk); is[2] = d2; iv[2] = 1'b1;
    @(posedge clk);
    @(negedge clk); iv[2] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 128'(ir[2]), 128'(1));
    chk("arst_out_valid", 128'(ov[2]), 128'(0));
    chk("arst_busy", 128'(bz[2]), 128'(0));
    chk("arst_out_state", os[2], '0);
    @(negedge clk); #2 rst_n = 1'b1;
    txn(2, 128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb);
    txn(4, d1, e1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
